tm1638_seq: RTL and testbench

TM1638_SEQ -- requirements
Module: tm1638_seq

---
 rtl/tm1638_seq.sv | 151 +++++++++++++++
 tb/tb_tm1638_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_seq.sv
// TM1638 frame sequencer: sends mode, address+16 data bytes, and display-control
// transactions over a bit-banged strobe/clock/data interface from one divider counter.
module tm1638_seq #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] seg,
    input  logic [7:0]  led,
    input  logic [2:0]  bright,
    input  logic        disp_on,
    output logic        busy,
    output logic        done,
    output logic        tm_clk,
    output logic        tm_stb,
    output logic        tm_dio
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic             half_q;   // SHIFT: 0 = clock-low half, 1 = clock-high half
    logic [2:0]       bit_q;
    logic [4:0]       byte_q;
    logic [1:0]       trans_q;
    logic             done_q;
    logic [63:0]      seg_q;
    logic [7:0]       led_q;
    logic [2:0]       bright_q;
    logic             on_q;

    logic             tick;
    logic             last_bit;
    logic [3:0]       pair_idx;
    logic [7:0]       cur_byte;

    assign tick     = (div_q == DIV_MAX);
    assign last_bit = half_q && (bit_q == 3'd7) &&
                      (byte_q == ((trans_q == 2'd1) ? 5'd16 : 5'd0));
    assign pair_idx = byte_q[3:0] - 4'd1;

    // T2 interleaves digit bytes (even) with single-bit LED bytes (odd) after the 0xC0 address.
    always_comb begin
        unique case (trans_q)
            2'd0:    cur_byte = 8'h40;
            2'd1:    cur_byte = (byte_q == 5'd0) ? 8'hC0 :
                                pair_idx[0] ? {7'b0, led_q[pair_idx[3:1]]} :
                                              seg_q[{pair_idx[3:1], 3'b000} +: 8];
            default: cur_byte = {4'h8, on_q, bright_q};
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start)            state_d = SETUP;
            SETUP: if (tick)             state_d = SHIFT;
            SHIFT: if (tick && last_bit) state_d = GAP;
            GAP:   if (tick && half_q)   state_d = (trans_q == 2'd2) ? IDLE : SETUP;
        endcase
    end

    // NOTE: shadow registers are plain flops, so they take the async reset like every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            half_q   <= 1'b0;
            bit_q    <= 3'd0;
            byte_q   <= 5'd0;
            trans_q  <= 2'd0;
            done_q   <= 1'b0;
            seg_q    <= 64'd0;
            led_q    <= 8'd0;
            bright_q <= 3'd0;
            on_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        seg_q    <= seg;
                        led_q    <= led;
                        bright_q <= bright;
                        on_q     <= disp_on;
                        trans_q  <= 2'd0;
                    end
                end
                SETUP: div_q <= tick ? '0 : div_q + 1'b1;
                SHIFT: begin
                    div_q <= tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        half_q <= ~half_q;
                        if (half_q) begin
                            if (bit_q == 3'd7) begin
                                bit_q  <= 3'd0;
                                byte_q <= last_bit ? 5'd0 : byte_q + 5'd1;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                            end
                        end
                    end
                end
                GAP: begin
                    div_q <= tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        half_q <= ~half_q;
                        if (half_q) begin
                            if (trans_q == 2'd2) begin
                                trans_q <= 2'd0;
                                done_q  <= 1'b1;
                            end else begin
                                trans_q <= trans_q + 2'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = done_q;
        tm_clk = 1'b1;
        tm_stb = 1'b1;
        tm_dio = 1'b1;
        unique case (state_q)
            IDLE:  ;
            SETUP: tm_stb = 1'b0;
            SHIFT: begin
                tm_stb = 1'b0;
                tm_clk = half_q;
                tm_dio = cur_byte[bit_q];
            end
            GAP:   ;
        endcase
    end

endmodule

// File: tb/tb_tm1638_seq.sv
// Bench for tm1638_seq: frame-offset pin model, serial decoder, protocol checks,
// directed frame/ignore/back-to-back/abort scenarios, then randomized traffic.
module tb_tm1638_seq;

    localparam int D     = 2;
    localparam int FRAME = 313 * D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] seg = 64'd0;
    logic [7:0]  led = 8'd0;
    logic [2:0]  bright = 3'd0;
    logic        disp_on = 1'b0;
    logic        busy, done, tm_clk, tm_stb, tm_dio;

    int checks = 0;
    int failures = 0;

    tm1638_seq #(.CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seg(seg), .led(led),
        .bright(bright), .disp_on(disp_on), .busy(busy), .done(done),
        .tm_clk(tm_clk), .tm_stb(tm_stb), .tm_dio(tm_dio)
    );

    always #5 clk = ~clk;

    logic [7:0] lit [19] = '{8'h40, 8'hC0, 8'hEF, 8'h01, 8'hCD, 8'h00, 8'hAB, 8'h01, 8'h89,
                             8'h00, 8'h67, 8'h00, 8'h45, 8'h01, 8'h23, 8'h00, 8'h01, 8'h01, 8'h8D};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: frame offset m_k (-1 when idle) and the byte list captured at acceptance.
    logic [7:0] m_bytes [19];
    int         m_k = -1;
    logic       m_done = 1'b0;

    function automatic void build_frame(input logic [63:0] s, input logic [7:0] l,
                                        input logic [2:0] b, input logic o);
        m_bytes[0] = 8'h40;
        m_bytes[1] = 8'hC0;
        for (int i = 0; i < 8; i++) begin
            m_bytes[2 + 2 * i] = s[8 * i +: 8];
            m_bytes[3 + 2 * i] = {7'b0, l[i]};
        end
        m_bytes[18] = {4'h8, o, b};
    endfunction

    // Expected {tm_clk, tm_stb, tm_dio} at frame offset k.
    function automatic logic [2:0] exp_pins(input int k);
        int j, n, base, s, bitn;
        if (k < 19 * D)       begin j = k;          n = 1;  base = 0;  end
        else if (k < 294 * D) begin j = k - 19 * D;  n = 17; base = 1;  end
        else                  begin j = k - 294 * D; n = 1;  base = 18; end
        if (j < D) return 3'b101;
        if (j >= D + 16 * n * D) return 3'b111;
        s    = j - D;
        bitn = s / (2 * D);
        return {(s % (2 * D)) >= D, 1'b0, m_bytes[base + bitn / 8][bitn % 8]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k    = -1;
            m_done = 1'b0;
        end else if (m_k >= 0) begin
            m_k++;
            m_done = 1'b0;
            if (m_k == FRAME) begin
                m_k    = -1;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_k = 0;
                build_frame(seg, led, bright, disp_on);
            end
        end
    end

    logic [2:0] ep;
    logic       p_clk = 1'b1, p_stb = 1'b1, p_dio = 1'b1, p_busy = 1'b0;
    int         run = 0;
    logic [7:0] dec_sr = 8'd0;
    int         dec_bits = 0;
    logic [7:0] dec_q [$];

    always @(negedge clk) begin
        ep = (m_k >= 0) ? exp_pins(m_k) : 3'b111;
        check("busy", busy, m_k >= 0);
        check("done", done, m_done);
        check("tm_clk", tm_clk, ep[2]);
        check("tm_stb", tm_stb, ep[1]);
        check("tm_dio", tm_dio, ep[0]);
        // Data may move while the clock is low, or while strobe is high (bus released).
        if (tm_dio !== p_dio) check("dio_change_phase", (!tm_clk) || tm_stb, 1'b1);
        if (tm_stb !== p_stb) check("stb_change_phase", tm_clk, 1'b1);
        if (!rst_n) begin
            run      = 0;
            dec_bits = 0;
            dec_q.delete();
            p_busy   = 1'b0;
        end else begin
            if (busy) run++;
            else if (p_busy) begin
                check("busy_cycles", run, 626);
                run = 0;
            end
            if (!tm_stb && !p_clk && tm_clk) begin
                dec_sr = {tm_dio, dec_sr[7:1]};
                dec_bits++;
                if (dec_bits == 8) begin
                    dec_q.push_back(dec_sr);
                    dec_bits = 0;
                end
            end
            if (tm_stb && !p_stb) check("byte_align", dec_bits, 0);
            p_busy = busy;
        end
        p_clk = tm_clk;
        p_stb = tm_stb;
        p_dio = tm_dio;
    end

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL done_timeout no done within %0d cycles", budget);
        end
    endtask

    task automatic check_decoded(input int nframes);
        check("dec_len", dec_q.size(), 19 * nframes);
        for (int i = 0; i < dec_q.size() && i < 19 * nframes; i++)
            check("dec_byte", dec_q[i], lit[i % 19]);
        dec_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_idle_now(input string name);
        check({name, "_clk"}, tm_clk, 1'b1);
        check({name, "_stb"}, tm_stb, 1'b1);
        check({name, "_dio"}, tm_dio, 1'b1);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_done"}, done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_idle_now("reset");
        seg     = 64'h0123456789ABCDEF;
        led     = 8'hA5;
        bright  = 3'd5;
        disp_on = 1'b1;

        // Start accepted on the first edge after reset release.
        #1 rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("first_edge_busy", busy, 1'b1);
        check("first_edge_stb", tm_stb, 1'b0);
        for (int i = 0; i < 19; i++) check("model_byte", m_bytes[i], lit[i]);
        wait_done(2000);
        check_decoded(1);

        // Start and input changes mid-frame are ignored.
        pulse_start();
        repeat (98) @(negedge clk);
        #1 seg = 64'hFFFF_0000_5555_AAAA;
        led = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        seg = 64'h0123456789ABCDEF;
        led = 8'hA5;
        wait_done(2000);
        check_decoded(1);

        // Back-to-back: start raised in the done cycle.
        pulse_start();
        wait_done(2000);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        check("b2b_setup_stb", tm_stb, 1'b0);
        check("b2b_setup_clk", tm_clk, 1'b1);
        wait_done(2000);
        check_decoded(2);

        // Abort during T2 byte 5, then a clean frame.
        pulse_start();
        repeat (19 * D + D + 5 * 16 * D + 1) @(negedge clk);
        check("abort_in_frame", busy, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_now("abort");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        pulse_start();
        wait_done(2000);
        check_decoded(1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            start = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) seg = {$urandom(), $urandom()};
            led     = 8'($urandom());
            bright  = 3'($urandom());
            disp_on = 1'($urandom());
            rst_n   = !((c == 1234) || ($urandom_range(0, 1499) == 0));
        end
        @(negedge clk);
        #1 start = 1'b0;
        rst_n = 1'b1;
        repeat (FRAME + 20) @(negedge clk);
        check_idle_now("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
